// File: rtl/decim_pkg.sv
// Shared constants, types and helpers for the 10x decimation filter.
package decim_pkg;
    localparam int unsigned PHASES = 10;
    localparam int unsigned ACC_W  = 15;
    localparam int unsigned RECIP  = 655;
    localparam int unsigned ROUND  = 32768;
    localparam int unsigned PROD_W = 25;

    typedef logic [3:0]       phase_t;
    typedef logic [ACC_W-1:0] acc_t;

    localparam phase_t PH_LAST = phase_t'(PHASES - 1);
    localparam phase_t PH_GAIN = phase_t'(PHASES);

    // Classification of one clock's enable/phase combination.
    typedef enum logic [2:0] {
        EV_IDLE,
        EV_SAMPLE,
        EV_EXTRA,
        EV_BOUNDARY,
        EV_STRAY
    } frame_ev_e;

    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    endfunction
endpackage

// File: rtl/decim_normalizer.sv
// Scales a completed accumulator by 1/100 (Q16 multiply, round, saturate);
// two clocks from input to output.
module decim_normalizer
    import decim_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ACC_W-1:0] i_acc,
    input  logic             i_valid,
    output logic [7:0]       o_sample,
    output logic             o_valid
);
    localparam logic [PROD_W-1:0] RECIP_P = PROD_W'(RECIP);
    localparam logic [PROD_W:0]   ROUND_P = (PROD_W + 1)'(ROUND);

    logic [PROD_W-1:0] r_prod;
    logic              r_prod_vld;
    logic [PROD_W:0]   w_rounded;
    logic [PROD_W:0]   w_shifted;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
        end else begin
            r_prod     <= PROD_W'(i_acc) * RECIP_P;
            r_prod_vld <= i_valid;
        end
    end

    always_comb begin
        w_rounded = {1'b0, r_prod} + ROUND_P;
        w_shifted = w_rounded >> 16;
    end

    // Output only moves on a valid result so it holds between frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_sample <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= r_prod_vld;
            if (r_prod_vld) begin
                o_sample <= (|w_shifted[PROD_W:8]) ? 8'hFF : w_shifted[7:0];
            end
        end
    end
endmodule

// File: rtl/decimator_10x.sv
// 10:1 decimator with a 19-tap triangular filter; phase tracking, dual
// accumulators and framing checks, followed by the normalizer.
module decimator_10x
    import decim_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       clk_en_10x,
    input  logic [7:0] sample_in,
    output logic [7:0] sample_out,
    output logic       sample_valid,
    output logic       frame_err
);
    phase_t    r_phase;
    acc_t      r_acc_a;
    acc_t      r_acc_b;
    logic      r_primed;
    acc_t      r_norm_acc;
    logic      r_norm_vld;
    logic      r_frame_err;

    frame_ev_e w_ev;
    phase_t    w_phase_nxt;
    phase_t    w_wgt_a;
    acc_t      w_term_a;
    acc_t      w_term_b;
    acc_t      w_acc_a_nxt;
    acc_t      w_acc_b_nxt;

    always_comb begin
        w_ev = EV_IDLE;
        if (clk_en && clk_en_10x) begin
            w_ev = EV_BOUNDARY;
        end else if (clk_en) begin
            w_ev = EV_STRAY;
        end else if (clk_en_10x) begin
            w_ev = (r_phase == PH_LAST) ? EV_EXTRA : EV_SAMPLE;
        end
    end

    // Extra samples reuse the saturated phase, giving phase-9 weights.
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_ev == EV_BOUNDARY) begin
            w_phase_nxt = '0;
        end else if (r_phase != PH_LAST) begin
            w_phase_nxt = r_phase + 4'd1;
        end
        w_wgt_a  = PH_GAIN - w_phase_nxt;
        w_term_a = acc_t'(sample_in) * acc_t'(w_wgt_a);
        w_term_b = acc_t'(sample_in) * acc_t'(w_phase_nxt);
    end

    always_comb begin
        w_acc_a_nxt = r_acc_a;
        w_acc_b_nxt = r_acc_b;
        unique case (w_ev)
            EV_BOUNDARY: begin
                w_acc_a_nxt = sat_add(r_acc_b, w_term_a);
                w_acc_b_nxt = '0;
            end
            EV_SAMPLE, EV_EXTRA: begin
                w_acc_a_nxt = sat_add(r_acc_a, w_term_a);
                w_acc_b_nxt = sat_add(r_acc_b, w_term_b);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase     <= '0;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_primed    <= 1'b0;
            r_norm_acc  <= '0;
            r_norm_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_acc_a     <= w_acc_a_nxt;
            r_acc_b     <= w_acc_b_nxt;
            r_frame_err <= (w_ev == EV_STRAY) || (w_ev == EV_EXTRA);
            r_norm_vld  <= 1'b0;
            if (w_ev == EV_BOUNDARY) begin
                r_phase    <= '0;
                r_norm_acc <= r_acc_a;
                r_norm_vld <= r_primed;
                r_primed   <= 1'b1;
            end else if (w_ev == EV_SAMPLE || w_ev == EV_EXTRA) begin
                r_phase <= w_phase_nxt;
            end
        end
    end

    assign frame_err = r_frame_err;

    decim_normalizer u_norm (
        .clk      (clk),
        .reset    (reset),
        .i_acc    (r_norm_acc),
        .i_valid  (r_norm_vld),
        .o_sample (sample_out),
        .o_valid  (sample_valid)
    );
endmodule

// File: tb/tb_decimator_10x.sv
// Randomized bench for decimator_10x against a frame-level weighted-sum model.
module tb_decimator_10x;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b0;
    logic       clk_en_10x = 1'b0;
    logic [7:0] sample_in = '0;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    decimator_10x dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .clk_en_10x   (clk_en_10x),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: samples of the current and previous frame with their phases;
    // each window is sum((10-p)*x) over its frame plus sum(p*x) over the one before.
    int cur_x[$], cur_p[$], prev_x[$], prev_p[$];
    int exp_due[$], exp_val[$];
    int m_pos, m_out, edge_n;
    bit m_primed, m_err;
    logic [7:0] fr [0:31];

    function automatic int norm(input int acc);
        int a, y;
        a = (acc > 32767) ? 32767 : acc;
        y = (a * 655 + 32768) / 65536;
        return (y > 255) ? 255 : y;
    endfunction

    function automatic int window_sum();
        int s = 0;
        foreach (cur_x[i])  s += (10 - cur_p[i]) * cur_x[i];
        foreach (prev_x[i]) s += prev_p[i] * prev_x[i];
        return s;
    endfunction

    task automatic model_reset();
        cur_x.delete(); cur_p.delete(); prev_x.delete(); prev_p.delete();
        exp_due.delete(); exp_val.delete();
        m_pos = 0; m_out = 0; m_primed = 0; m_err = 0;
    endtask

    task automatic model_step(input bit en, input bit en10, input int x);
        m_err = 0;
        if (en && en10) begin
            if (m_primed) begin
                exp_due.push_back(edge_n + 2);
                exp_val.push_back(norm(window_sum()));
            end
            m_primed = 1;
            prev_x = cur_x; prev_p = cur_p;
            cur_x.delete(); cur_p.delete();
            cur_x.push_back(x); cur_p.push_back(0);
            m_pos = 0;
        end else if (en) begin
            m_err = 1;
        end else if (en10) begin
            if (m_pos == 9) m_err = 1;
            else m_pos++;
            cur_x.push_back(x); cur_p.push_back(m_pos);
        end
    endtask

    task automatic check_cycle();
        bit exp_v = 0;
        if (exp_due.size() > 0 && exp_due[0] == edge_n) begin
            exp_v = 1;
            m_out = exp_val[0];
            void'(exp_due.pop_front());
            void'(exp_val.pop_front());
        end
        check_eq("sample_valid", 32'(sample_valid), 32'(exp_v));
        check_eq("sample_out", 32'(sample_out), m_out);
        check_eq("frame_err", 32'(frame_err), 32'(m_err));
    endtask

    // Called at a negedge: drive, let one active edge pass, check at the next negedge.
    task automatic tick(input bit en, input bit en10, input logic [7:0] x);
        clk_en = en; clk_en_10x = en10; sample_in = x;
        @(posedge clk);
        edge_n++;
        model_step(en, en10, int'(x));
        @(negedge clk);
        check_cycle();
    endtask

    task automatic fill(input int n, input int v);
        for (int i = 0; i < n; i++) fr[i] = 8'(v);
    endtask

    task automatic send_frame(input int n, input bit gaps, input int stray_at);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 2)) tick(0, 0, 8'($urandom));
            if (i == stray_at) tick(1, 0, 8'($urandom));
            tick(i == 0, 1, fr[i]);
        end
    endtask

    task automatic const_frames(input int cnt, input int v);
        fill(10, v);
        repeat (cnt) send_frame(10, 0, -1);
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out", 32'(sample_out), 0);
        check_eq("rst_valid", 32'(sample_valid), 0);
        check_eq("rst_err", 32'(frame_err), 0);
        reset = 1'b1;

        // Constant mid-scale, regular frames.
        const_frames(6, 8'h80);
        check_eq("const80", 32'(sample_out), 32'h80);

        // Full scale must saturate cleanly rather than wrap.
        const_frames(4, 8'hFF);
        check_eq("constFF", 32'(sample_out), 32'hFF);

        // Impulses at phase 0 and phase 5.
        const_frames(2, 0);
        fill(10, 0); fr[0] = 8'hFF; send_frame(10, 0, -1);
        check_eq("imp0_before", 32'(sample_out), 0);
        const_frames(1, 0);
        check_eq("imp0_win", 32'(sample_out), 32'h19);
        const_frames(1, 0);
        check_eq("imp0_after", 32'(sample_out), 0);
        fill(10, 0); fr[5] = 8'd100; send_frame(10, 0, -1);
        const_frames(1, 0);
        check_eq("imp5_win_n", 32'(sample_out), 5);
        const_frames(1, 0);
        check_eq("imp5_win_n1", 32'(sample_out), 5);
        const_frames(1, 0);
        check_eq("imp5_after", 32'(sample_out), 0);

        // Eleven pulses in one frame.
        const_frames(2, 8'h80);
        fill(11, 8'h80); send_frame(11, 0, -1);
        const_frames(1, 8'h80);
        check_eq("extra_win", 32'(sample_out), 129);

        // Enough extras to drive the accumulators into saturation.
        fill(30, 8'hFF); send_frame(30, 1, -1);
        const_frames(2, 8'hFF);
        check_eq("sat_recover", 32'(sample_out), 32'hFF);

        // Stray clk_en in the middle of a frame must leave the filter untouched.
        const_frames(2, 8'h80);
        fill(10, 8'h80); send_frame(10, 0, 4);
        const_frames(1, 8'h80);
        check_eq("stray_win", 32'(sample_out), 32'h80);

        // Random frames: lengths 1..12, gaps, occasional stray enable.
        for (int f = 0; f < 40; f++) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) fr[i] = 8'($urandom);
            send_frame(n, 1, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : -1);
        end

        // Reset in the middle of a frame.
        const_frames(3, 8'h80);
        check_eq("pre_reset_out", 32'(sample_out), 32'h80);
        fill(10, 8'h80); send_frame(4, 0, -1);
        clk_en = 0; clk_en_10x = 0;
        reset = 1'b0;
        #1;
        check_eq("arst_out", 32'(sample_out), 0);
        check_eq("arst_valid", 32'(sample_valid), 0);
        check_eq("arst_err", 32'(frame_err), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick(0, 1, 8'h80);
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 10; i++) fr[i] = 8'($urandom);
            send_frame(10, 1, -1);
        end
        repeat (4) tick(0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
